// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter (SRL/SRLV/SRA/SRAV) for the MIPS datapath.
// Moves at most STEP bit positions per clock; done pulses when out_put is updated.
module shift_right_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               arith,
  input  logic [WIDTH-1:0]   in_put,
  input  logic [SHAMT_W-1:0] N,
  output logic [WIDTH-1:0]   out_put,
  output logic               busy,
  output logic               done
);

  // Step arithmetic is one bit wider than the count so STEP itself always fits.
  localparam int SW = (SHAMT_W >= 5) ? SHAMT_W + 1 : 6;
  localparam logic [SW-1:0] STEP_V = SW'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   acc_r, acc_s;
  logic [WIDTH-1:0]   out_r, out_s;
  logic [SHAMT_W-1:0] cnt_r, cnt_s;
  logic               fill_r, fill_s;
  logic               busy_r;
  logic               done_r, done_s;
  logic [SW-1:0]      cnt_ext_s;
  logic [SW-1:0]      step_s;
  logic [WIDTH-1:0]   fill_mask_s;
  logic [WIDTH-1:0]   shifted_s;

  // One shift step: clamp to remaining count, fill vacated MSBs from the captured sign
  always_comb begin
    cnt_ext_s = {{(SW-SHAMT_W){1'b0}}, cnt_r};
    if (cnt_ext_s >= STEP_V) begin
      step_s = STEP_V;
    end else begin
      step_s = cnt_ext_s;
    end
    fill_mask_s = ~({WIDTH{1'b1}} >> step_s);
    if (fill_r) begin
      shifted_s = (acc_r >> step_s) | fill_mask_s;
    end else begin
      shifted_s = acc_r >> step_s;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    fill_s  = fill_r;
    out_s   = out_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          acc_s   = in_put;
          cnt_s   = N;
          fill_s  = arith & in_put[WIDTH-1];
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == {SHAMT_W{1'b0}}) begin
          out_s   = acc_r;
          done_s  = 1'b1;
          state_s = DONE;
        end else begin
          acc_s = shifted_s;
          cnt_s = cnt_r - step_s[SHAMT_W-1:0];
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; busy is registered from the next state to stay glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      acc_r   <= {WIDTH{1'b0}};
      cnt_r   <= {SHAMT_W{1'b0}};
      fill_r  <= 1'b0;
      out_r   <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      fill_r  <= fill_s;
      out_r   <= out_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= done_s;
    end
  end

  assign out_put = out_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_shift_right_seq.sv
// Randomised self-checking bench for shift_right_seq: STEP=1 and STEP=4 instances run
// the same operations and are compared against plain shift arithmetic and ceil(N/STEP) latency.
module tb_shift_right_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        arith = 1'b0;
  logic [31:0] in_put = 32'h0;
  logic [4:0]  n_amt = 5'd0;
  logic [31:0] out1, out4;
  logic        busy1, busy4, done1, done4;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] prev1 = 32'h0;
  logic [31:0] prev4 = 32'h0;

  always #5 clk = ~clk;

  shift_right_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .arith(arith), .in_put(in_put),
    .N(n_amt), .out_put(out1), .busy(busy1), .done(done1)
  );

  shift_right_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .arith(arith), .in_put(in_put),
    .N(n_amt), .out_put(out4), .busy(busy4), .done(done4)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation on both instances; optional busy-time start pulse and input scrambling.
  task automatic run_op(input logic [31:0] x, input logic [4:0] n, input logic a,
                        input bit rej, input bit scramble);
    logic [31:0] exp_r;
    int k1, k4;
    int dc1, dc4, p1, p4;
    exp_r = a ? 32'($signed(x) >>> n) : (x >> n);
    k1 = int'(n);
    k4 = (int'(n) + 3) / 4;
    dc1 = -1; dc4 = -1; p1 = 0; p4 = 0;
    start = 1'b1; in_put = x; n_amt = n; arith = a;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("hold1", out1, prev1);
    check_val("hold4", out4, prev4);
    check_val("busy_e0_1", {31'b0, busy1}, 32'h1);
    check_val("busy_e0_4", {31'b0, busy4}, 32'h1);
    if (scramble) begin
      in_put = $urandom; n_amt = 5'($urandom); arith = 1'($urandom);
    end
    for (int c = 1; c <= 36; c++) begin
      if (c == 2 && rej) begin
        start = 1'b1; in_put = 32'h1;
      end
      if (c == 3) start = 1'b0;
      @(posedge clk); #1;
      if (done1) begin
        p1++;
        if (dc1 < 0) begin dc1 = c; check_val("result1", out1, exp_r); end
      end
      if (done4) begin
        p4++;
        if (dc4 < 0) begin dc4 = c; check_val("result4", out4, exp_r); end
      end
      if (c == k1 + 1) check_val("busy_last1", {31'b0, busy1}, 32'h1);
      if (c == k1 + 2) check_val("busy_clr1", {31'b0, busy1}, 32'h0);
      if (c == k4 + 1) check_val("busy_last4", {31'b0, busy4}, 32'h1);
      if (c == k4 + 2) check_val("busy_clr4", {31'b0, busy4}, 32'h0);
    end
    start = 1'b0;
    check_val("latency1", 32'(dc1), 32'(k1 + 1));
    check_val("latency4", 32'(dc4), 32'(k4 + 1));
    check_val("pulses1", 32'(p1), 32'h1);
    check_val("pulses4", 32'(p4), 32'h1);
    check_val("final1", out1, exp_r);
    check_val("final4", out4, exp_r);
    prev1 = exp_r;
    prev4 = exp_r;
  endtask

  initial begin
    int pulses;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out1", out1, 32'h0);
    check_val("rst_out4", out4, 32'h0);
    check_val("rst_busy", {30'b0, busy1, busy4}, 32'h0);
    check_val("rst_done", {30'b0, done1, done4}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'hDEADBEEF, 5'd0,  1'b0, 1'b0, 1'b0);
    run_op(32'h80000000, 5'd5,  1'b0, 1'b0, 1'b0);
    run_op(32'h80000000, 5'd31, 1'b1, 1'b0, 1'b0);
    run_op(32'h80000000, 5'd31, 1'b0, 1'b0, 1'b0);
    run_op(32'h000000F0, 5'd4,  1'b0, 1'b1, 1'b0);
    run_op(32'hC0000000, 5'd7,  1'b1, 1'b0, 1'b0);
    run_op(32'h7FFFFFFF, 5'd31, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of a long shift
    start = 1'b1; in_put = 32'hA5A5A5A5; n_amt = 5'd20; arith = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", {30'b0, busy1, busy4}, 32'h0);
    check_val("midrst_done", {30'b0, done1, done4}, 32'h0);
    check_val("midrst_out1", out1, 32'h0);
    check_val("midrst_out4", out4, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done1 || done4 || busy1 || busy4) pulses++;
    end
    check_val("midrst_quiet", 32'(pulses), 32'h0);
    prev1 = 32'h0;
    prev4 = 32'h0;

    for (int i = 0; i < 1000; i++) begin
      run_op($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
